// File: rtl/mult_div.sv
// Iterative radix-2 multiply/divide unit for MULT, MULTU, DIV and DIVU.
// One shift-add (multiply) or restoring subtract-shift (divide) step per clock.
module mult_div #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [5:0]                  funct,
    input  logic [DATA_WIDTH-1:0]       operand_1,
    input  logic [DATA_WIDTH-1:0]       operand_2,
    input  logic                        flush,
    input  logic                        advance,
    output logic                        done,
    output logic [2*DATA_WIDTH-1:0]     result
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] counter_q, counter_d;
    logic                 done_q, done_d;
    logic [2*W-1:0]       result_q, result_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         opb_q, opb_d;
    logic [W-1:0]         op1_raw_q, op1_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;

    logic                 is_mul_s, is_divop_s, signed_s, start_s;
    logic [W:0]           mul_sum_s, rem_sh_s, rem_new_s;
    logic                 ge_s;
    logic [2*W-1:0]       step_s, final_s;
    logic [W-1:0]         mag1_s, mag2_s;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
        logic [W-1:0] m;
        if (sgn && v[W-1]) begin
            m = ~v + W'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Decode the funct field and form the start qualifier
    always_comb begin
        is_mul_s   = (funct == F_MULT) || (funct == F_MULTU);
        is_divop_s = (funct == F_DIV)  || (funct == F_DIVU);
        signed_s   = (funct == F_MULT) || (funct == F_DIV);
        start_s    = (state_q == IDLE) && en && (is_mul_s || is_divop_s) && !flush;
        mag1_s     = magnitude(operand_1, signed_s);
        mag2_s     = magnitude(operand_2, signed_s);
    end

    // One radix-2 iteration plus the sign-corrected final result
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        // Remainder needs W+1 bits after the shift since it can reach 2*divisor-1
        rem_sh_s  = {acc_q[2*W-1:W], acc_q[W-1]};
        ge_s      = rem_sh_s >= {1'b0, opb_q};
        if (ge_s) begin
            rem_new_s = rem_sh_s - {1'b0, opb_q};
        end else begin
            rem_new_s = rem_sh_s;
        end
        if (is_div_q) begin
            step_s = {rem_new_s[W-1:0], acc_q[W-2:0], ge_s};
        end else begin
            step_s = {mul_sum_s, acc_q[W-1:1]};
        end
        if (is_div_q && dz_q) begin
            final_s = {op1_raw_q, {W{1'b1}}};
        end else if (is_div_q) begin
            final_s[2*W-1:W] = neg_rem_q ? (~step_s[2*W-1:W] + W'(1)) : step_s[2*W-1:W];
            final_s[W-1:0]   = neg_q ? (~step_s[W-1:0] + W'(1)) : step_s[W-1:0];
        end else begin
            final_s = neg_q ? (~step_s + (2*W)'(1)) : step_s;
        end
    end

    // Next-state and register updates for the IDLE/BUSY/DONE sequence
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        done_d    = done_q;
        result_d  = result_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op1_raw_d = op1_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start_s) begin
                    state_d   = BUSY;
                    counter_d = CNT_WIDTH'(0);
                    is_div_d  = is_divop_s;
                    op1_raw_d = operand_1;
                    neg_d     = signed_s && (operand_1[W-1] ^ operand_2[W-1]);
                    neg_rem_d = signed_s && is_divop_s && operand_1[W-1];
                    dz_d      = is_divop_s && (operand_2 == W'(0));
                    if (is_divop_s) begin
                        acc_d = {{W{1'b0}}, mag1_s};
                        opb_d = mag2_s;
                    end else begin
                        acc_d = {{W{1'b0}}, mag2_s};
                        opb_d = mag1_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    acc_d     = step_s;
                    counter_d = counter_q + CNT_WIDTH'(1);
                    if (counter_q == CNT_WIDTH'(W - 1)) begin
                        result_d = final_s;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            DONE: begin
                if (advance || flush) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            counter_q <= CNT_WIDTH'(0);
            done_q    <= 1'b0;
            result_q  <= {(2*W){1'b0}};
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    // Datapath registers: accumulator, second operand and sign-fix flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= {(2*W){1'b0}};
            opb_q     <= {W{1'b0}};
            op1_raw_q <= {W{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op1_raw_q <= op1_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: vector table plus hand-written flush,
// hold and asynchronous-reset sequences, with a queue scoreboard of results.
module tb_mult_div;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst, en, flush, advance;
    logic [5:0]  funct;
    logic [31:0] op1, op2;
    logic        done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[12];

    mult_div dut (
        .clk(clk), .rst(rst), .en(en), .funct(funct),
        .operand_1(op1), .operand_2(op2), .flush(flush),
        .advance(advance), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit track);
        @(negedge clk);
        en = 1'b1; funct = f; op1 = a; op2 = b;
        if (track) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        en = 1'b0; funct = 6'($urandom); op1 = $urandom; op2 = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    task automatic finish_op(input string name, input int hold);
        int lat;
        wait_done(lat);
        check64({name, " latency"}, 64'(lat), 64'd32);
        if (exp_q.size() != 0) begin
            last_exp = exp_q.pop_front();
            check64({name, " result"}, result, last_exp);
        end else begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check64({name, " hold done"}, {63'd0, done}, 64'd1);
            check64({name, " hold result"}, result, last_exp);
        end
        @(negedge clk);
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0;
        check64({name, " done cleared"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int highs;
        vecs[0]  = '{F_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
        vecs[1]  = '{F_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
        vecs[3]  = '{F_DIVU,  32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC};
        vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[5]  = '{F_DIVU,  32'd100,      32'd0,        64'h00000064_FFFFFFFF};
        vecs[6]  = '{F_DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF};
        vecs[7]  = '{F_MULT,  32'd7,        32'hFFFFFFF7, 64'hFFFFFFFF_FFFFFFC1};
        vecs[8]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[9]  = '{F_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
        vecs[10] = '{F_MULTU, 32'h12345678, 32'h9ABCDEF0, 64'h12345678 * 64'h9ABCDEF0};
        vecs[11] = '{F_DIVU,  32'd1000,     32'd7,        {32'd6, 32'd142}};

        rst = 1'b0; en = 1'b0; flush = 1'b0; advance = 1'b0;
        funct = 6'd0; op1 = 32'd0; op2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check64("reset done", {63'd0, done}, 64'd0);
        check64("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Non-mult/div funct, then en=0: no start
        @(negedge clk);
        en = 1'b1; funct = 6'h20; op1 = 32'd5; op2 = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check64("bad funct idle", {63'd0, done}, 64'd0);
        en = 1'b0; funct = F_MULT;
        repeat (3) @(posedge clk);
        #1;
        check64("en low idle", {63'd0, done}, 64'd0);

        // Flush and start together: flush wins
        @(negedge clk);
        en = 1'b1; funct = F_MULTU; flush = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; flush = 1'b0;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) highs++;
        end
        check64("flush+start no done", 64'(highs), 64'd0);

        // MULTU max x max with a 5-cycle hold before advance
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
        finish_op("multu_max", 5);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            finish_op($sformatf("vec%0d", i), 0);
        end

        // Flush a DIVU at iteration 10
        issue(F_DIVU, 32'd12345, 32'd17, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check64("flush busy done", {63'd0, done}, 64'd0);
        check64("flush keeps result", result, last_exp);
        @(posedge clk);
        #1;
        check64("after flush idle", {63'd0, done}, 64'd0);
        issue(F_MULTU, 32'd3, 32'd4, 64'd12, 1'b1);
        finish_op("multu_after_flush", 0);

        // Asynchronous reset at iteration 20 of a MULT
        issue(F_MULT, 32'h00001234, 32'hFFFFFFFE, 64'd0, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check64("async rst done", {63'd0, done}, 64'd0);
        check64("async rst result", result, 64'd0);
        en = 1'b1; funct = F_MULTU; op1 = 32'd7; op2 = 32'd6;
        exp_q.push_back(64'd42);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        finish_op("rst_restart", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits beside the EX stage. It takes the funct code and both operands from ID/EX and returns a 64-bit {HI, LO} result plus a done flag.
- EX holds its stall request while a mult/div instruction is resident and done is low.
- One radix-2 step per clock: shift-add for multiply, restoring subtract-shift for divide.

Parameters:
- DATA_WIDTH, 32: operand width. The result is 2*DATA_WIDTH wide.
- CNT_WIDTH, 5: iteration counter width. Must satisfy 2^CNT_WIDTH = DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  EX holds a valid, non-bubble instruction this cycle.
- funct  input  6  funct field of the EX instruction.
- operand_1  input  32  rs value: multiplicand or dividend.
- operand_2  input  32  rt value: multiplier or divisor.
- flush  input  1  pipeline flush (exception or eret); aborts any operation.
- advance  input  1  the EX instruction leaves EX at this edge.
- done  output  1  result valid for the current EX mult/div instruction.
- result  output  64  [63:32] goes to HI, [31:0] goes to LO.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, done=0, result=0, counter=0, all datapath registers cleared.
- Reset mid-operation discards the operation with no partial result.
- Funct codes: MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B.
- Start condition: state IDLE, en=1, funct is one of the four codes above, flush=0.

States: IDLE, BUSY, DONE.
- IDLE:
  - On a start edge, latch |operand_1| and |operand_2| (magnitudes for signed ops, raw values for unsigned).
  - Latch the sign-fix flags and the op type; clear counter; go to BUSY.
  - done=0.
- BUSY: one iteration per edge, counter increments.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator, then shift the accumulator right 1.
  - Divide: shift {rem, quot} left 1; if rem ≥ divisor, subtract the divisor and set the quot LSB.
  - On the edge where counter==DATA_WIDTH-1, write the final iteration to result with sign correction applied, set done=1, and go to DONE.
  - done therefore rises after the 32nd edge following the start edge.
- Sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - MULTU and DIVU: no correction.
- DONE:
  - done=1 and result are held stable.
  - On advance=1 or flush=1, go to IDLE and set done=0 at that edge.
  - A new start is accepted no earlier than the following edge.
- Divide by zero (operand_2==0 at start):
  - Runs the normal 32-cycle latency.
  - Result is forced to hi=operand_1 (as latched), lo=32'hFFFFFFFF, regardless of signedness.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. There is no trap; HI/LO ops never set overflow.
- Flush in BUSY: go to IDLE at that edge, done stays 0, result keeps its previous value.
- Flush and start in the same cycle: flush wins, no start.
- Operand or funct changes while BUSY or DONE are ignored; the operands were latched at start.
- en=0 or a non-mult/div funct in IDLE: stays in IDLE, done=0.
- Start is sampled only in IDLE, so back-to-back mult/div instructions each take the full latency plus one IDLE edge.
- Single always block per register group; no combinational path from any input to done or result.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, en=1 → done rises on the 32nd edge after the start edge; result=0xFFFFFFFE_00000001; done and result held while advance=0 for 5 cycles, then IDLE one edge after advance=1.
- MULT 0xFFFFFFFD (-3) × 5 → result=0xFFFFFFFF_FFFFFFF1. MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
- DIV 0xFFFFFFF9 (-7) / 2 → hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIVU 0xFFFFFFF9 / 2 → hi=1, lo=0x7FFFFFFC. DIV 0x80000000 / 0xFFFFFFFF → hi=0, lo=0x80000000.
- DIVU 100 / 0 and DIV -5 / 0 → done after 32 cycles; hi=100 and hi=0xFFFFFFFB respectively; lo=0xFFFFFFFF in both.
- Start DIVU, assert flush at iteration 10 → done never rises and state is IDLE. A MULTU 3×4 started two edges later → result=12 after 32 cycles.
- Drop rst at iteration 20 of a MULT → done=0 and result=0 immediately, without waiting for a clock edge. Release rst with en=1, funct=MULTU → new operation starts on the first edge after release.
